// File: rtl/gesture_pkg.sv
// Shared types and constants for the gesture pipeline: sequencer states,
// coordinate width, default image size and the palm result record.
package gesture_pkg;
  localparam int COORD_W   = 8;
  localparam int DEF_IMG_W = 120;
  localparam int DEF_IMG_H = 160;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic               found;
    logic [COORD_W-1:0] start_r;
    logic [COORD_W-1:0] start_c;
    logic [COORD_W-1:0] width;
    logic [COORD_W-1:0] height;
  } palm_rec_t;

  // A miss reports an all-zero box regardless of what the identifier drives.
  function automatic palm_rec_t mask_rec(input palm_rec_t r);
    palm_rec_t m;
    m = r.found ? r : '0;
    return m;
  endfunction
endpackage

// File: rtl/frame_pixel_counter.sv
// Raster row/column counter for one frame; advances once per accepted pixel
// and flags the final pixel of the frame.
module frame_pixel_counter
  import gesture_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               last_pixel
);
  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(IMG_H - 1);

  logic end_of_row;

  assign end_of_row = (col == COL_MAX);
  assign last_pixel = end_of_row && (row == ROW_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (end_of_row) begin
        col <= '0;
        row <= last_pixel ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/gesture_frame_sequencer.sv
// Frame controller for the palm identifier: clear, stream one frame with
// indices, wait out identifier latency, then hand one result record downstream.
module gesture_frame_sequencer
  import gesture_pkg::*;
#(
  parameter int IMG_W        = DEF_IMG_W,
  parameter int IMG_H        = DEF_IMG_H,
  parameter int CLEAR_CYCLES = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter bit AUTO_RESTART = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pix_valid,
  input  logic               pix_data,
  output logic               pix_ready,
  output logic               pid_clear,
  output logic               pid_pixel,
  output logic               pid_pixel_valid,
  output logic [COORD_W-1:0] pid_row,
  output logic [COORD_W-1:0] pid_col,
  input  logic               pid_found,
  input  logic [COORD_W-1:0] pid_start_r,
  input  logic [COORD_W-1:0] pid_start_c,
  input  logic [COORD_W-1:0] pid_width,
  input  logic [COORD_W-1:0] pid_height,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_found,
  output logic [COORD_W-1:0] res_start_r,
  output logic [COORD_W-1:0] res_start_c,
  output logic [COORD_W-1:0] res_width,
  output logic [COORD_W-1:0] res_height,
  output logic [COORD_W-1:0] frame_count,
  output logic               busy
);
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  seq_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [COORD_W-1:0] row, col;
  logic               last_pixel;
  logic               accept;
  logic               cnt_clear;
  palm_rec_t          pid_rec, cap_rec;

  assign pix_ready = (state == ST_STREAM);
  assign accept    = pix_valid & pix_ready;
  assign busy      = (state != ST_IDLE);
  assign cnt_clear = (state == ST_CLEAR);

  assign pid_rec = '{found: pid_found, start_r: pid_start_r, start_c: pid_start_c,
                     width: pid_width, height: pid_height};
  assign cap_rec = mask_rec(pid_rec);

  frame_pixel_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pix_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .advance    (accept),
    .row        (row),
    .col        (col),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      pid_clear       <= 1'b0;
      pid_pixel       <= 1'b0;
      pid_pixel_valid <= 1'b0;
      pid_row         <= '0;
      pid_col         <= '0;
      res_valid       <= 1'b0;
      res_found       <= 1'b0;
      res_start_r     <= '0;
      res_start_c     <= '0;
      res_width       <= '0;
      res_height      <= '0;
      frame_count     <= '0;
    end else begin
      pid_pixel_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_CLEAR;
            pid_clear <= 1'b1;
            cnt       <= '0;
          end
        end
        ST_CLEAR: begin
          if (cnt == CLR_LAST) begin
            state     <= ST_STREAM;
            pid_clear <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STREAM: begin
          // The frame always runs to its last pixel so upstream stays aligned.
          if (accept) begin
            pid_pixel       <= pix_data;
            pid_pixel_valid <= 1'b1;
            pid_row         <= row;
            pid_col         <= col;
            if (last_pixel) begin
              state <= ST_DRAIN;
              cnt   <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (cnt == DRN_LAST) begin
            state       <= ST_REPORT;
            res_valid   <= 1'b1;
            res_found   <= cap_rec.found;
            res_start_r <= cap_rec.start_r;
            res_start_c <= cap_rec.start_c;
            res_width   <= cap_rec.width;
            res_height  <= cap_rec.height;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_REPORT: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            frame_count <= frame_count + 1'b1;
            if (AUTO_RESTART) begin
              state     <= ST_CLEAR;
              pid_clear <= 1'b1;
              cnt       <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/gesture_frame_sequencer.md
Name: gesture_frame_sequencer

Overview:
Frame-level controller for the palm identification datapath. Accepts one binary segmented frame from the segmentation stage over a valid/ready stream and clears the palm identifier before each frame. Forwards pixels with row/column indices, waits out the identifier's latency, captures its results, and presents one result record per frame to the gesture classifier over a valid/ready handshake.

Parameters:
IMG_W, 120, pixels per row (columns), 1..255
IMG_H, 160, rows per frame, 1..255
CLEAR_CYCLES, 2, cycles pid_clear is held asserted before streaming, >=1
DRAIN_CYCLES, 3, cycles waited after last pixel before sampling results, >=1
AUTO_RESTART, 0, 1 = go straight to CLEAR after result handshake instead of IDLE

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset; one clock; reset polarity and synchronicity are fixed
start  in  1  level/pulse; sampled only in IDLE, begins a frame
pix_valid  in  1  upstream pixel valid
pix_data  in  1  upstream pixel, 1 = hand pixel
pix_ready  out  1  sequencer accepts pixel this cycle
pid_clear  out  1  synchronous clear to palm identifier, active-high
pid_pixel  out  1  registered copy of accepted pixel
pid_pixel_valid  out  1  pid_pixel is valid this cycle
pid_row  out  8  row index of pid_pixel
pid_col  out  8  column index of pid_pixel
pid_found  in  1  identifier has locked a palm
pid_start_r, pid_start_c  in  8 each  palm start coordinates from identifier
pid_width, pid_height  in  8 each  palm width/height from identifier
res_valid  out  1  result record valid
res_ready  in  1  downstream accepts record
res_found  out  1  palm found in this frame
res_start_r, res_start_c, res_width, res_height  out  8 each  captured results
frame_count  out  8  completed (handshaken) frames, wraps 255->0
busy  out  1  state != IDLE

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; counters 0; frame_count 0. Reset mid-frame abandons the frame; no record is emitted.
- States: IDLE, CLEAR, STREAM, DRAIN, REPORT.
- IDLE: pix_ready=0. start=1 -> CLEAR next cycle.
- CLEAR: pid_clear=1 for exactly CLEAR_CYCLES cycles; row/col counters reset to 0; -> STREAM.
- STREAM: pix_ready=1 combinationally. A pixel is accepted when pix_valid&pix_ready. One cycle later: pid_pixel_valid=1, pid_pixel=pix_data, pid_row/pid_col hold the indices of that pixel (latency 1). With no acceptance, pid_pixel_valid=0 and pid_pixel/row/col hold their values.
- Counters: col increments per accepted pixel; at col==IMG_W-1, col->0 and row++. Accepting pixel (IMG_H-1, IMG_W-1) -> DRAIN; pix_ready deasserts the following cycle. No extra pixel is accepted.
- pid_found asserting during STREAM does not shorten the frame. The remaining pixels are still consumed and forwarded, which keeps upstream frame-aligned.
- DRAIN: pix_ready=0; count DRAIN_CYCLES (the final forwarded pixel leaves on the first DRAIN cycle). On the last drain cycle, capture pid_found and the four results. If pid_found=0, res_start_r/c, res_width and res_height are captured as 0. -> REPORT.
- REPORT: res_valid=1 and res_* stable until res_valid&res_ready. On handshake: frame_count++ (mod 256); res_valid=0 next cycle. Next state is CLEAR if AUTO_RESTART=1, else IDLE.
- res_* retain their last captured values after REPORT until the next capture.
- start outside IDLE is ignored. res_ready outside REPORT is ignored.
- A zero-latency handshake is allowed: res_ready already high on REPORT entry completes in 1 cycle.

Decomposition:
- Shared package (gesture_pkg): state encoding constant, 8-bit coordinate width constant, default IMG_W/IMG_H. The same image dimensions are used by the segmentation and palm identification stages.
- One natural sub-module: frame_pixel_counter (row/col counter with IMG_W/IMG_H, advance input, last_pixel output).
- The FSM, pixel register and result capture stay in the top.

Test Plan:
- Reset mid-STREAM at pixel (5,10): assert rst low -> next cycle busy=0, pix_ready=0, res_valid=0, frame_count=0; new start re-clears and streams from (0,0).
- IMG_W=4, IMG_H=3, pix_valid always 1 -> exactly 12 pixels accepted; pid_clear high for 2 cycles; pid_col sequence 0,1,2,3,0..., pid_row 0,0,0,0,1...; pid_row/pid_col = 2/3 on the last forwarded pixel.
- Same frame with pix_valid toggling 1010... -> still 12 accepted; pid_pixel_valid pulses only on accepted cycles; indices are unchanged by the gaps.
- pid_found=1, start_r=40, start_c=30, width=25, height=37 at drain end; res_ready low 5 cycles -> res_valid held 5+ cycles with those values; frame_count 0->1 at handshake.
- pid_found=0 with nonzero pid_width=9 -> res_found=0 and all res_* fields 0.
- AUTO_RESTART=1, frame_count preset by running 256 frames -> wraps to 0; CLEAR entered on the cycle after each handshake without start.
